// File: rtl/ising_multi_sampler_if.sv
// ising_multi_sampler_if: control, oscillator and result signals between the run controller and its host.
// master drives the batch controls and the oscillator outputs.
// slave is the sampler: it drives core_rstn, busy, the per-run results and the voted result.
interface ising_multi_sampler_if #(
    parameter int N     = 3,
    parameter int CNT_W = 32,
    parameter int RUN_W = 8
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] counter_max;
    logic [CNT_W-1:0] counter_cutoff;
    logic [RUN_W-1:0] num_runs;
    logic [N-1:0]     outputs_ver;
    logic [N-1:0]     outputs_hor;
    logic             core_rstn;
    logic             busy;
    logic [N-1:0]     run_phase;
    logic             run_valid;
    logic [RUN_W-1:0] run_idx;
    logic [N-1:0]     phase;
    logic             done;
    modport master (
        output start, abort, counter_max, counter_cutoff, num_runs, outputs_ver, outputs_hor,
        input  core_rstn, busy, run_phase, run_valid, run_idx, phase, done
    );
    modport slave (
        input  start, abort, counter_max, counter_cutoff, num_runs, outputs_ver, outputs_hor,
        output core_rstn, busy, run_phase, run_valid, run_idx, phase, done
    );
endinterface

// File: rtl/ising_multi_sampler.sv
// ising_multi_sampler: sequences num_runs anneals of the oscillator core and majority-votes the measured spins.
// Ports: clk (system clock), ising_rst (async active-high reset),
//        bus (slave modport): start/abort/counter_max/counter_cutoff/num_runs/outputs_ver/outputs_hor in,
//        core_rstn/busy/run_phase/run_valid/run_idx/phase/done out.
module ising_multi_sampler #(
    parameter int N           = 3,
    parameter int CNT_W       = 32,
    parameter int RUN_W       = 8,
    parameter int RST_CYCLES  = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic ising_rst,
    ising_multi_sampler_if.slave bus
);
    localparam int RC_W = $clog2(RST_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, CORE_RST, MEASURE, DECIDE, FINISH} state_t;
    state_t           r_state;
    logic [N-1:0]     r_ver_s [SYNC_STAGES];
    logic [N-1:0]     r_hor_s [SYNC_STAGES];
    logic [CNT_W-1:0] r_max, r_cut, r_cyc;
    logic [CNT_W-1:0] r_mcnt [N];
    logic [RUN_W-1:0] r_vote [N];
    logic [RUN_W-1:0] r_runs, r_run;
    logic [RC_W-1:0]  r_rcnt;
    logic             r_core_rstn, r_busy, r_run_valid, r_done;
    logic [N-1:0]     r_run_phase, r_phase;
    logic [RUN_W-1:0] r_run_idx;
    logic [N-1:0]     w_mm, w_bits, w_phase;
    logic [CNT_W-1:0] w_win;
    logic             w_last, w_more;
    assign bus.core_rstn = r_core_rstn;
    assign bus.busy      = r_busy;
    assign bus.run_phase = r_run_phase;
    assign bus.run_valid = r_run_valid;
    assign bus.run_idx   = r_run_idx;
    assign bus.phase     = r_phase;
    assign bus.done      = r_done;
    assign w_mm   = r_ver_s[SYNC_STAGES-1] ^ r_hor_s[SYNC_STAGES-1];
    // counter_max of 0 still measures for one cycle
    assign w_last = r_cyc == ((r_max == '0) ? '0 : r_max - CNT_W'(1));
    assign w_win  = (r_cut >= r_max) ? '0 : r_max - r_cut;
    assign w_more = (r_run + RUN_W'(1)) < r_runs;
    // doubled counts compared one bit wider so 2*x cannot overflow; an empty window votes 0
    always_comb begin
        w_bits  = '0;
        w_phase = '0;
        for (int i = 0; i < N; i++) begin
            w_bits[i]  = (w_win != '0) && ({r_mcnt[i], 1'b0} > {1'b0, w_win});
            w_phase[i] = {r_vote[i], 1'b0} > {1'b0, r_runs};
        end
    end
    always_ff @(posedge clk or posedge ising_rst) begin
        if (ising_rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_ver_s[k] <= '0;
                r_hor_s[k] <= '0;
            end
        end else begin
            r_ver_s[0] <= bus.outputs_ver;
            r_hor_s[0] <= bus.outputs_hor;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_ver_s[k] <= r_ver_s[k-1];
                r_hor_s[k] <= r_hor_s[k-1];
            end
        end
    end
    always_ff @(posedge clk or posedge ising_rst) begin
        if (ising_rst) begin
            r_state     <= IDLE;
            r_max       <= '0;
            r_cut       <= '0;
            r_cyc       <= '0;
            r_runs      <= '0;
            r_run       <= '0;
            r_rcnt      <= '0;
            r_core_rstn <= 1'b0;
            r_busy      <= 1'b0;
            r_run_valid <= 1'b0;
            r_done      <= 1'b0;
            r_run_phase <= '0;
            r_phase     <= '0;
            r_run_idx   <= '0;
            for (int i = 0; i < N; i++) begin
                r_mcnt[i] <= '0;
                r_vote[i] <= '0;
            end
        end else begin
            r_run_valid <= 1'b0;
            r_done      <= 1'b0;
            if (bus.abort && r_state != IDLE) begin
                r_state     <= IDLE;
                r_busy      <= 1'b0;
                r_core_rstn <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: if (bus.start && !bus.abort) begin
                        r_max   <= bus.counter_max;
                        r_cut   <= bus.counter_cutoff;
                        r_runs  <= (bus.num_runs == '0) ? RUN_W'(1) : bus.num_runs;
                        r_run   <= '0;
                        r_rcnt  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= CORE_RST;
                        for (int i = 0; i < N; i++) begin
                            r_mcnt[i] <= '0;
                            r_vote[i] <= '0;
                        end
                    end
                    CORE_RST: if (r_rcnt == RC_W'(RST_CYCLES - 1)) begin
                        r_state     <= MEASURE;
                        r_core_rstn <= 1'b1;
                        r_cyc       <= '0;
                    end else begin
                        r_rcnt <= r_rcnt + RC_W'(1);
                    end
                    MEASURE: begin
                        for (int i = 0; i < N; i++)
                            if (r_cyc >= r_cut && w_mm[i] && !(&r_mcnt[i]))
                                r_mcnt[i] <= r_mcnt[i] + CNT_W'(1);
                        r_cyc   <= r_cyc + CNT_W'(1);
                        r_state <= w_last ? DECIDE : MEASURE;
                    end
                    DECIDE: begin
                        r_run_phase <= w_bits;
                        r_run_idx   <= r_run;
                        r_run_valid <= 1'b1;
                        r_run       <= r_run + RUN_W'(1);
                        r_core_rstn <= 1'b0;
                        r_rcnt      <= '0;
                        for (int i = 0; i < N; i++) begin
                            r_vote[i] <= r_vote[i] + RUN_W'(w_bits[i]);
                            r_mcnt[i] <= '0;
                        end
                        r_state <= w_more ? CORE_RST : FINISH;
                    end
                    FINISH: begin
                        r_phase <= w_phase;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ising_multi_sampler.sv
// tb_ising_multi_sampler: directed checks of run timing, thresholds, voting, abort and async reset.
module tb_ising_multi_sampler;
    localparam int N = 3, CNT_W = 32, RUN_W = 8;
    logic clk = 1'b0, rst = 1'b1, tog = 1'b0;
    logic [N-1:0] base_ver = '0, base_hor = '0;
    int checks = 0, errors = 0;
    int lat, rise, nvalid, dn;
    int pulse_at = -1, pulse_len = 0, start_at = -1, clr_idx = -1;
    logic [N-1:0]     rp [8];
    logic [RUN_W-1:0] ri [8];
    always #5 clk = ~clk;
    always @(negedge clk) tog <= ~tog;
    ising_multi_sampler_if #(.N(N), .CNT_W(CNT_W), .RUN_W(RUN_W)) bus ();
    ising_multi_sampler #(.N(N), .CNT_W(CNT_W), .RUN_W(RUN_W), .RST_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .ising_rst(rst), .bus(bus)
    );
    // both oscillators toggle together, so only base_ver ^ base_hor sets the mismatch
    assign bus.outputs_ver = base_ver ^ {N{tog}};
    assign bus.outputs_hor = base_hor ^ {N{tog}};
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic kick();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask
    task automatic go(input logic [CNT_W-1:0] mx, input logic [CNT_W-1:0] cut, input logic [RUN_W-1:0] runs, input int limit);
        bus.counter_max    = mx;
        bus.counter_cutoff = cut;
        bus.num_runs       = runs;
        kick();
        lat = 0;
        nvalid = 0;
        rise = -1;
        while (lat < limit) begin
            @(posedge clk);
            #1;
            lat++;
            bus.start = (lat == start_at);
            if (lat == pulse_at) base_hor[0] = ~base_ver[0];
            if (lat == pulse_at + pulse_len) base_hor[0] = base_ver[0];
            if (bus.core_rstn && rise < 0) rise = lat;
            if (bus.run_valid && nvalid < 8) begin
                rp[nvalid] = bus.run_phase;
                ri[nvalid] = bus.run_idx;
                if (nvalid == clr_idx) base_hor = base_ver;
                nvalid++;
            end
            if (bus.done) break;
        end
        check("done_seen", bus.done, 1);
    endtask
    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.counter_max = '0;
        bus.counter_cutoff = '0;
        bus.num_runs = '0;
        #12;
        check("rst_core_rstn", bus.core_rstn, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_phase", bus.phase, 0);
        check("rst_run_phase", bus.run_phase, 0);
        check("rst_run_valid", bus.run_valid, 0);
        check("rst_run_idx", bus.run_idx, 0);
        check("rst_done", bus.done, 0);
        @(negedge clk) rst = 1'b0;
        // 1: all in phase
        base_ver = 3'b101;
        base_hor = 3'b101;
        go(100, 20, 1, 300);
        check("t1_lat", lat, 106);
        check("t1_rise", rise, 4);
        check("t1_nvalid", nvalid, 1);
        check("t1_run_phase", rp[0], 3'b000);
        check("t1_phase", bus.phase, 3'b000);
        check("t1_busy", bus.busy, 0);
        check("t1_core_rstn", bus.core_rstn, 0);
        // 2: spin 0 out of phase the whole window
        base_hor = base_ver ^ 3'b001;
        go(100, 20, 1, 300);
        check("t2_run_phase", rp[0], 3'b001);
        check("t2_phase", bus.phase, 3'b001);
        // 2: 41 of 80 mismatching cycles is a majority, 40 is not
        base_hor = base_ver;
        pulse_at = 40;
        pulse_len = 41;
        go(100, 20, 1, 300);
        check("t2_41of80", rp[0], 3'b001);
        pulse_len = 40;
        go(100, 20, 1, 300);
        check("t2_40of80", rp[0], 3'b000);
        check("t2_40_phase", bus.phase, 3'b000);
        pulse_at = -1;
        pulse_len = 0;
        // 3: three runs, spin 1 out of phase in runs 0 and 1
        base_hor = base_ver ^ 3'b010;
        clr_idx = 1;
        go(20, 4, 3, 300);
        check("t3_lat", lat, 76);
        check("t3_nvalid", nvalid, 3);
        check("t3_idx0", ri[0], 0);
        check("t3_idx1", ri[1], 1);
        check("t3_idx2", ri[2], 2);
        check("t3_rp0", rp[0], 3'b010);
        check("t3_rp1", rp[1], 3'b010);
        check("t3_rp2", rp[2], 3'b000);
        check("t3_phase", bus.phase, 3'b010);
        // 3: two runs, one vote -> tie -> 0
        base_hor = base_ver ^ 3'b010;
        clr_idx = 0;
        go(20, 4, 2, 300);
        check("t3_tie_nvalid", nvalid, 2);
        check("t3_tie_rp0", rp[0], 3'b010);
        check("t3_tie_rp1", rp[1], 3'b000);
        check("t3_tie_phase", bus.phase, 3'b000);
        clr_idx = -1;
        // 4: start while busy is ignored
        base_hor = base_ver ^ 3'b100;
        start_at = 10;
        go(20, 4, 1, 300);
        start_at = -1;
        check("t4_lat", lat, 26);
        check("t4_phase", bus.phase, 3'b100);
        tick(3);
        check("t4_no_restart", bus.busy, 0);
        // 4: abort in MEASURE
        base_hor = base_ver ^ 3'b011;
        bus.counter_max = 100;
        bus.counter_cutoff = 20;
        bus.num_runs = 1;
        kick();
        tick(10);
        check("t4_busy_pre", bus.busy, 1);
        check("t4_rstn_pre", bus.core_rstn, 1);
        @(negedge clk) bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        check("t4_abort_busy", bus.busy, 0);
        check("t4_abort_rstn", bus.core_rstn, 0);
        dn = 0;
        repeat (150) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.run_valid) dn++;
        end
        check("t4_abort_nodone", dn, 0);
        check("t4_abort_phase", bus.phase, 3'b100);
        // 4: abort beats start in the same cycle
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("t4_both_busy", bus.busy, 0);
        // 5: cutoff == max gives an empty window
        base_hor = ~base_ver;
        go(100, 100, 1, 300);
        check("t5_lat", lat, 106);
        check("t5_nvalid", nvalid, 1);
        check("t5_run_phase", rp[0], 3'b000);
        check("t5_phase", bus.phase, 3'b000);
        // 5: max = 0 measures one cycle
        go(0, 0, 1, 50);
        check("t5_max0_lat", lat, 7);
        check("t5_max0_nvalid", nvalid, 1);
        // 6: async reset mid-MEASURE
        base_hor = base_ver ^ 3'b110;
        go(20, 4, 1, 100);
        check("t6_pre_phase", bus.phase, 3'b110);
        bus.counter_max = 100;
        bus.num_runs = 1;
        kick();
        tick(20);
        @(negedge clk) rst = 1'b1;
        #1;
        check("t6_busy", bus.busy, 0);
        check("t6_rstn", bus.core_rstn, 0);
        check("t6_phase", bus.phase, 0);
        check("t6_run_phase", bus.run_phase, 0);
        @(negedge clk) rst = 1'b0;
        base_hor = base_ver ^ 3'b001;
        go(20, 4, 1, 100);
        check("t6_after_lat", lat, 26);
        check("t6_after_phase", bus.phase, 3'b001);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
